// File: rtl/data_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_pkg
// Description : Shared state encoding and default geometry for data_ram.
// Revision    : 1.0  initial release
// ============================================================================
package data_ram_pkg;

    localparam int c_DEFAULT_DATA_W = 8;
    localparam int c_DEFAULT_ADDR_W = 8;
    localparam int c_DEFAULT_DEPTH  = 256;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/data_ram_if.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_if
// Description : Command/response bundle between a requester and data_ram.
// Revision    : 1.0  initial release
// ============================================================================
interface data_ram_if #(
    parameter int DATA_W = data_ram_pkg::c_DEFAULT_DATA_W,
    parameter int ADDR_W = data_ram_pkg::c_DEFAULT_ADDR_W
);

    logic              req_valid;
    logic              req_ready;
    logic              write_enable;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] data_out;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, write_enable, addr, data_in, rsp_ready,
        input  req_ready, rsp_valid, data_out, rsp_err, busy
    );

    modport slave (
        input  req_valid, write_enable, addr, data_in, rsp_ready,
        output req_ready, rsp_valid, data_out, rsp_err, busy
    );

endinterface
`default_nettype wire

// File: rtl/data_ram_array.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_array
// Description : DEPTH x DATA_W storage, one synchronous write and one
//               synchronous read port, no reset.
// Revision    : 1.0  initial release
// ============================================================================
module data_ram_array #(
    parameter int DATA_W = data_ram_pkg::c_DEFAULT_DATA_W,
    parameter int DEPTH  = data_ram_pkg::c_DEFAULT_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              i_wr_en,
    input  wire logic [IDX_W-1:0]  i_wr_addr,
    input  wire logic [DATA_W-1:0] i_wr_data,
    input  wire logic              i_rd_en,
    input  wire logic [IDX_W-1:0]  i_rd_addr,
    output logic      [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_ram.sv
`default_nettype none
// ============================================================================
// Module      : data_ram
// Description : Single-port word RAM with valid/ready command and response
//               handshake, range checking and an optional zero sweep after
//               reset (compiled in by DATA_RAM_CLEAR_EN).
// Revision    : 1.0  initial release
// ============================================================================
module data_ram #(
    parameter int DATA_W = data_ram_pkg::c_DEFAULT_DATA_W,
    parameter int ADDR_W = data_ram_pkg::c_DEFAULT_ADDR_W,
    parameter int DEPTH  = data_ram_pkg::c_DEFAULT_DEPTH
) (
    input wire logic  clk,
    input wire logic  rst_n,
    data_ram_if.slave bus
);

    import data_ram_pkg::*;

    localparam int c_IDX_W = $clog2(DEPTH);

`ifdef DATA_RAM_CLEAR_EN
    localparam state_t            c_RST_STATE = CLEAR;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DEPTH - 1);
`else
    localparam state_t            c_RST_STATE = IDLE;
`endif

    state_t              r_state;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic                r_rd_sel;

    logic [ADDR_W-1:0]   w_addr;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_in_range;
    logic                w_req_ready;
    logic                w_accept;
    logic                w_wr_cmd;
    logic                w_wr_en;
    logic [c_IDX_W-1:0]  w_wr_addr;
    logic [DATA_W-1:0]   w_wr_data;
    logic                w_rd_en;
    logic [DATA_W-1:0]   w_rd_data;

    assign w_addr     = bus.addr;
    assign w_idx      = w_addr[c_IDX_W-1:0];
    assign w_in_range = (32'(w_addr) < DEPTH);

    // In RESP a new command may ride on the same edge that consumes the response.
    always_comb begin
        w_req_ready = 1'b0;
        case (r_state)
            IDLE:    w_req_ready = 1'b1;
            RESP:    w_req_ready = bus.rsp_ready;
            default: w_req_ready = 1'b0;
        endcase
    end

    assign w_accept = rst_n & bus.req_valid & w_req_ready;
    assign w_wr_cmd = w_accept & bus.write_enable & w_in_range;
    assign w_rd_en  = w_accept & ~bus.write_enable & w_in_range;

`ifdef DATA_RAM_CLEAR_EN
    logic [c_IDX_W-1:0] r_clear_ptr;
    logic               w_clearing;

    assign w_clearing = (r_state == CLEAR);
    assign w_wr_en    = rst_n & (w_clearing | w_wr_cmd);
    assign w_wr_addr  = w_clearing ? r_clear_ptr : w_idx;
    assign w_wr_data  = w_clearing ? '0 : bus.data_in;
    assign bus.busy   = w_clearing;
`else
    assign w_wr_en    = w_wr_cmd;
    assign w_wr_addr  = w_idx;
    assign w_wr_data  = bus.data_in;
    assign bus.busy   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_RST_STATE;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rd_sel    <= 1'b0;
`ifdef DATA_RAM_CLEAR_EN
            r_clear_ptr <= '0;
`endif
        end else begin
            case (r_state)
`ifdef DATA_RAM_CLEAR_EN
                CLEAR: begin
                    if (r_clear_ptr == c_LAST_IDX) begin
                        r_clear_ptr <= '0;
                        r_state     <= IDLE;
                    end else begin
                        r_clear_ptr <= r_clear_ptr + 1'b1;
                    end
                end
`endif
                IDLE, RESP: begin
                    if (w_accept && !bus.write_enable) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= ~w_in_range;
                        r_rd_sel    <= w_in_range;
                    end else if (r_state == RESP && bus.rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Out-of-range reads and the reset state present zero instead of stale array data.
    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.data_out  = r_rd_sel ? w_rd_data : '0;

    data_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (c_IDX_W)
    ) u_array (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_idx),
        .o_rd_data (w_rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_data_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_ram
// Description : Self-checking bench for data_ram: transaction-level model,
//               per-cycle compare, directed cases and randomized traffic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_data_ram;

    localparam int c_DATA_W = 8;
    localparam int c_ADDR_W = 8;
    localparam int c_DEPTH  = 200;
`ifdef DATA_RAM_CLEAR_EN
    localparam bit c_CLR = 1'b1;
`else
    localparam bit c_CLR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    data_ram_if #(.DATA_W(c_DATA_W), .ADDR_W(c_ADDR_W)) bus ();

    data_ram #(
        .DATA_W (c_DATA_W),
        .ADDR_W (c_ADDR_W),
        .DEPTH  (c_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: memory image, pending response, sweep countdown.
    logic [7:0] m_mem   [c_DEPTH];
    bit         m_known [c_DEPTH];
    int         m_clear_left = 0;
    bit         m_pend  = 1'b0;
    logic [7:0] m_data  = 8'h00;
    bit         m_err   = 1'b0;
    bit         m_pknown = 1'b0;
    bit         m_acc   = 1'b0;
    bit         m_live  = 1'b0;

    function automatic bit m_ready();
        return (m_clear_left == 0) && (!m_pend || bus.rsp_ready);
    endfunction

    always @(posedge clk) begin
        bit rdy;
        int a;
        m_live = 1'b1;
        m_acc  = 1'b0;
        if (!rst_n) begin
            m_pend       = 1'b0;
            m_clear_left = c_CLR ? c_DEPTH : 0;
        end else if (m_clear_left > 0) begin
            m_mem[c_DEPTH - m_clear_left]   = 8'h00;
            m_known[c_DEPTH - m_clear_left] = 1'b1;
            m_clear_left--;
        end else begin
            rdy = m_ready();
            if (m_pend && bus.rsp_ready) m_pend = 1'b0;
            if (bus.req_valid && rdy) begin
                m_acc = 1'b1;
                a = int'(bus.addr);
                if (bus.write_enable) begin
                    if (a < c_DEPTH) begin
                        m_mem[a]   = bus.data_in;
                        m_known[a] = 1'b1;
                    end
                end else begin
                    m_pend   = 1'b1;
                    m_err    = (a >= c_DEPTH);
                    m_data   = m_err ? 8'h00 : m_mem[a];
                    m_pknown = m_err || m_known[a];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("busy", 32'(bus.busy), 32'(m_clear_left > 0));
            chk("req_ready", 32'(bus.req_ready), 32'(m_ready()));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_pend));
            if (m_pend) begin
                chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
                if (m_pknown) chk("data_out", 32'(bus.data_out), 32'(m_data));
            end
        end
    end

    // Present a command and hold it until accepted; returns at edge+1 after acceptance.
    task automatic issue(input bit we, input int a, input int d);
        int n;
        n = 0;
        bus.req_valid    = 1'b1;
        bus.write_enable = we;
        bus.addr         = a[7:0];
        bus.data_in      = d[7:0];
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!m_acc && n < 500);
        if (!m_acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got none expected acceptance of addr %0h", a);
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int n;
        bus.req_valid    = 1'b0;
        bus.write_enable = 1'b0;
        bus.addr         = '0;
        bus.data_in      = '0;
        bus.rsp_ready    = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'h0);
        chk("rst_data_out",  32'(bus.data_out),  32'h0);
`ifdef DATA_RAM_CLEAR_EN
        chk("rst_busy",      32'(bus.busy),      32'h1);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);

        // Abort the sweep at address 7, then time the full restarted sweep.
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("sweep_mid_busy", 32'(bus.busy), 32'h1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        while (bus.busy && n < 1000) begin
            chk("sweep_req_ready", 32'(bus.req_ready), 32'h0);
            @(posedge clk);
            #1;
            n++;
        end
        chk("busy_cycles", 32'(n), 32'(c_DEPTH));
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, i, 0);
            chk("clr_rd_data", 32'(bus.data_out), 32'h00);
            chk("clr_rd_err",  32'(bus.rsp_err),  32'h0);
        end
`else
        chk("rst_busy",      32'(bus.busy),      32'h0);
        rst_n = 1'b1;
        chk("first_req_ready", 32'(bus.req_ready), 32'h1);
        issue(1'b1, 8'h10, 8'h3C);
        issue(1'b0, 8'h10, 0);
        chk("rd_3c_valid", 32'(bus.rsp_valid), 32'h1);
        chk("rd_3c_data",  32'(bus.data_out),  32'h3C);
`endif

        issue(1'b1, 8'h04, 8'h5A);
        issue(1'b1, 8'hC7, 8'h77);
        issue(1'b1, 8'h03, 8'hA5);
        bus.rsp_ready = 1'b0;
        issue(1'b0, 8'h03, 0);
        chk("rd_a5_valid", 32'(bus.rsp_valid), 32'h1);
        chk("rd_a5_data",  32'(bus.data_out),  32'hA5);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(bus.rsp_valid), 32'h1);
            chk("hold_data",  32'(bus.data_out),  32'hA5);
            chk("hold_ready", 32'(bus.req_ready), 32'h0);
        end
        bus.rsp_ready = 1'b1;
        issue(1'b0, 8'h04, 0);
        chk("b2b_valid", 32'(bus.rsp_valid), 32'h1);
        chk("b2b_data",  32'(bus.data_out),  32'h5A);

        issue(1'b1, 8'hC8, 8'hFF);
        issue(1'b0, 8'hC8, 0);
        chk("oor_data", 32'(bus.data_out), 32'h00);
        chk("oor_err",  32'(bus.rsp_err),  32'h1);
        issue(1'b0, 8'hC7, 0);
        chk("c7_data", 32'(bus.data_out), 32'h77);
        chk("c7_err",  32'(bus.rsp_err),  32'h0);

        // Random traffic; an unaccepted command is held unchanged.
        for (int i = 0; i < 3000; i++) begin
            bus.rsp_ready = ($urandom_range(3) != 0);
            if (!(bus.req_valid && !m_acc)) begin
                bus.req_valid    = ($urandom_range(2) != 0);
                bus.write_enable = 1'($urandom_range(1));
                bus.addr         = 8'($urandom_range(255));
                bus.data_in      = 8'($urandom);
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
